// File: rtl/bcd_chk_pkg.sv
// Shared types and constants for the BCD sequence checker.
package bcd_chk_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SEQ     = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// One BCD counting step: next digit in the given direction plus a wrap flag
// (9->0 going up, 0->9 going down).
module bcd_step
  import bcd_chk_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_up,
  output logic [3:0] o_next,
  output logic       o_wrap
);

  // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    o_wrap = i_up ? (i_digit == BCD_MAX) : (i_digit == 4'd0);
    if (o_wrap) begin
      o_next = i_up ? 4'd0 : BCD_MAX;
    end else begin
      o_next = i_up ? (i_digit + 4'd1) : (i_digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_seq_checker.sv
// Passive monitor for a BCD up/down counter: flags illegal digits and sequence
// breaks, reports wraps. Define BCD_CHK_CARRY_EN to track a tens digit.
module bcd_seq_checker
  import bcd_chk_pkg::*;
#(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             mode,
  input  logic [3:0]       count,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [3:0]       tens
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_N);

  state_e           r_state;
  logic [3:0]       r_ref;
  logic             r_ref_m;
  logic [3:0]       r_lock_cnt;
  logic             r_locked;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             r_err_sticky;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_wrap_up;
  logic             r_wrap_dn;

  logic [3:0] w_exp;
  logic       w_wrap;
  logic       w_legal;
  logic       w_match;
  logic       w_err_evt;

  bcd_step u_exp_step (
    .i_digit (r_ref),
    .i_up    (r_ref_m),
    .o_next  (w_exp),
    .o_wrap  (w_wrap)
  );

  assign w_legal   = is_bcd(count);
  assign w_match   = (count == w_exp);
  assign w_err_evt = !w_legal || ((r_state == TRACK) && !w_match);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= SYNC;
      r_ref        <= 4'd0;
      r_ref_m      <= 1'b0;
      r_lock_cnt   <= 4'd0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_wrap_up    <= 1'b0;
      r_wrap_dn    <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_wrap_up  <= 1'b0;
      r_wrap_dn  <= 1'b0;

      if (w_err_evt) begin
        r_err_sticky <= 1'b1;
        if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end

      case (r_state)
        SYNC: begin
          if (w_legal) begin
            r_ref      <= count;
            r_ref_m    <= mode;
            r_lock_cnt <= 4'd0;
            r_locked   <= 1'b0;
            r_state    <= TRACK;
          end else begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ILLEGAL;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_ILLEGAL;
            r_locked   <= 1'b0;
            r_state    <= SYNC;
          end else if (w_match) begin
            r_ref   <= count;
            r_ref_m <= mode;
            if (r_lock_cnt != LOCK_MAX) r_lock_cnt <= r_lock_cnt + 4'd1;
            if (r_lock_cnt >= LOCK_MAX - 4'd1) r_locked <= 1'b1;
            r_wrap_up <= w_wrap && r_ref_m;
            r_wrap_dn <= w_wrap && !r_ref_m;
          end else begin
            // Resync on the observed value and keep tracking from there.
            r_err      <= 1'b1;
            r_err_code <= ERR_SEQ;
            r_locked   <= 1'b0;
            r_lock_cnt <= 4'd0;
            r_ref      <= count;
            r_ref_m    <= mode;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

`ifdef BCD_CHK_CARRY_EN
  logic [3:0] r_tens;
  logic [3:0] w_tens_next;
  logic       w_tens_wrap_unused;
  logic       w_wrap_evt;

  assign w_wrap_evt = (r_state == TRACK) && w_legal && w_match && w_wrap;

  bcd_step u_tens_step (
    .i_digit (r_tens),
    .i_up    (r_ref_m),
    .o_next  (w_tens_next),
    .o_wrap  (w_tens_wrap_unused)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_tens <= 4'd0;
    end else if (w_wrap_evt) begin
      r_tens <= w_tens_next;
    end
  end

  assign tens = r_tens;
`else
  assign tens = 4'd0;
`endif

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign wrap_up    = r_wrap_up;
  assign wrap_dn    = r_wrap_dn;

endmodule

// File: tb/tb_bcd_seq_checker.sv
// Directed self-checking bench for bcd_seq_checker (carry checks follow BCD_CHK_CARRY_EN).
module tb_bcd_seq_checker;

`ifdef BCD_CHK_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic       mode;
  logic [3:0] count;
  logic       locked;
  logic       err;
  logic [1:0] err_code;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       wrap_up;
  logic       wrap_dn;
  logic [3:0] tens;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seq_checker #(.LOCK_N(4), .ERR_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .mode       (mode),
    .count      (count),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wrap_up    (wrap_up),
    .wrap_dn    (wrap_dn),
    .tens       (tens)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one sample; outputs are read 1 time unit after the capturing edge.
  task automatic step(input logic [3:0] c, input logic m);
    count = c;
    mode  = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    mode  = 1'b1;
    count = 4'd11;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %0b expected 00", err_code); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %0d expected 0", err_sticky); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if ({wrap_up, wrap_dn} !== 2'b00) begin n_fail++; $display("FAIL reset_wraps: got %0b expected 00", {wrap_up, wrap_dn}); end
    n_checks++; if (tens !== 4'd0) begin n_fail++; $display("FAIL reset_tens: got %0d expected 0", tens); end
    clr = 1'b0;
  endtask

  task automatic test_up_count();
    logic [3:0] c;
    do_clr();
    for (int i = 0; i < 12; i++) begin
      c = 4'(i % 10);
      step(c, 1'b1);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL up_err[%0d]: got %0d expected 0", i, err); end
      n_checks++; if (locked !== (i >= 4)) begin n_fail++; $display("FAIL up_locked[%0d]: got %0d expected %0d", i, locked, (i >= 4)); end
      n_checks++; if (wrap_up !== (i == 10)) begin n_fail++; $display("FAIL up_wrap_up[%0d]: got %0d expected %0d", i, wrap_up, (i == 10)); end
    end
    n_checks++; if (tens !== (CARRY_EN ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL up_tens: got %0d expected %0d", tens, (CARRY_EN ? 1 : 0)); end
  endtask

  task automatic test_wrap_dn();
    logic [3:0] seq [3] = '{4'd0, 4'd9, 4'd8};
    do_clr();
    for (int i = 0; i < 3; i++) begin
      step(seq[i], 1'b0);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dn_err[%0d]: got %0d expected 0", i, err); end
      n_checks++; if (wrap_dn !== (i == 1)) begin n_fail++; $display("FAIL dn_wrap_dn[%0d]: got %0d expected %0d", i, wrap_dn, (i == 1)); end
    end
    n_checks++; if (tens !== (CARRY_EN ? 4'd9 : 4'd0)) begin n_fail++; $display("FAIL dn_tens: got %0d expected %0d", tens, (CARRY_EN ? 9 : 0)); end
  endtask

  task automatic test_seq_err();
    do_clr();
    step(4'd3, 1'b1);
    step(4'd4, 1'b1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL seq_pre_err: got %0d expected 0", err); end
    step(4'd6, 1'b1);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL seq_err: got %0d expected 1", err); end
    n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL seq_code: got %0b expected 10", err_code); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_cnt: got %0d expected 1", err_cnt); end
    step(4'd7, 1'b1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL seq_resync_err: got %0d expected 0", err); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL seq_resync_code: got %0b expected 00", err_code); end
    n_checks++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %0d expected 1", err_sticky); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_cnt_hold: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_illegal();
    do_clr();
    for (int i = 1; i <= 6; i++) step(4'(i), 1'b1);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ill_pre_locked: got %0d expected 1", locked); end
    step(4'd12, 1'b1);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %0d expected 1", err); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL ill_code: got %0b expected 01", err_code); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL ill_locked: got %0d expected 0", locked); end
    step(4'd5, 1'b1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_sync_err: got %0d expected 0", err); end
    step(4'd6, 1'b1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_track_err: got %0d expected 0", err); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_dir_change();
    logic [3:0] c_seq [4] = '{4'd4, 4'd5, 4'd4, 4'd3};
    logic       m_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_clr();
    for (int i = 0; i < 4; i++) begin
      step(c_seq[i], m_seq[i]);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dir_err[%0d]: got %0d expected 0", i, err); end
    end
  endtask

  task automatic test_clr_and_saturate();
    do_clr();
    for (int i = 0; i < 21; i++) step(4'(i % 10), 1'b1);
    repeat (3) step(4'd5, 1'b1);
    n_checks++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 3", err_cnt); end
    n_checks++; if (tens !== (CARRY_EN ? 4'd2 : 4'd0)) begin n_fail++; $display("FAIL mid_tens: got %0d expected %0d", tens, (CARRY_EN ? 2 : 0)); end
    #2;
    clr = 1'b1;
    #1;
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d expected 0", err_cnt); end
    n_checks++; if (tens !== 4'd0) begin n_fail++; $display("FAIL clr_tens: got %0d expected 0", tens); end
    n_checks++; if ({locked, err, err_sticky, wrap_up, wrap_dn} !== 5'b0) begin n_fail++; $display("FAIL clr_flags: got %05b expected 00000", {locked, err, err_sticky, wrap_up, wrap_dn}); end
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 255; i++) step(4'd15, 1'b1);
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_255: got %0d expected 255", err_cnt); end
    repeat (5) step(4'd15, 1'b1);
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt_hold: got %0d expected 255", err_cnt); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL sat_code: got %0b expected 01", err_code); end
    step(4'd0, 1'b1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sat_recover_err: got %0d expected 0", err); end
    n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_recover_cnt: got %0d expected 255", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap_dn();
    test_seq_err();
    test_illegal();
    test_dir_change();
    test_clr_and_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
